// File: rtl/dutypattern_loader_pkg.sv
// Shared types and defaults for the duty-pattern loader.
package dutypattern_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Default pattern width in bits.
  localparam int PATTERN_W_DEF = 32;

  // Pattern held after reset: lower half ones, i.e. 50 % duty.
  localparam logic [31:0] DEFAULT_PATTERN_DEF = 32'h0000FFFF;

  // Width of the committed-frame counter.
  localparam int FRAME_COUNT_W = 8;

endpackage

// File: rtl/dutypattern_loader_if.sv
// FIFO read port seen by the duty-pattern loader.
// Handshake: FIFO_RD_EN is a registered strobe from the loader. The FIFO pops
// one bit at every clock edge that samples FIFO_RD_EN high while FIFO_EMPTY
// is low, and presents that bit on FIFO_DOUT for the whole following cycle.
// FIFO_PROG_FULL high means at least one full pattern is queued.
interface dutypattern_loader_if;
  logic FIFO_PROG_FULL;
  logic FIFO_EMPTY;
  logic FIFO_DOUT;
  logic FIFO_RD_EN;

  // Loader side: consumes status and data, drives the read strobe.
  modport master (
    input  FIFO_PROG_FULL,
    input  FIFO_EMPTY,
    input  FIFO_DOUT,
    output FIFO_RD_EN
  );

  // FIFO side: drives status and data, consumes the read strobe.
  modport slave (
    output FIFO_PROG_FULL,
    output FIFO_EMPTY,
    output FIFO_DOUT,
    input  FIFO_RD_EN
  );
endinterface

// File: rtl/dutypattern_loader_deser.sv
// Serial-to-parallel shifter: first captured bit ends up in the MSB.
module dutypattern_deser
  import dutypattern_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 cap_en_i,
  input  logic                 din_i,
  output logic [PATTERN_W-1:0] word_o,
  output logic                 last_o
);

  localparam int CNT_W = $clog2(PATTERN_W + 1);

  logic [PATTERN_W-1:0] word_q;
  logic [CNT_W-1:0]     cnt_q;

  // Shift in one bit per capture; clear wins so a discarded frame leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (cap_en_i) begin
      word_q <= (word_q << 1) | PATTERN_W'(din_i);
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign word_o = word_q;
  // High during the cycle whose edge captures the final bit of the word.
  assign last_o = cap_en_i && !clear_i && (cnt_q == CNT_W'(PATTERN_W - 1));

endmodule

// File: rtl/dutypattern_loader.sv
// Reads PATTERN_W serial bits from a FIFO, assembles them MSB first and
// commits the word to PATTERN_OUT with a one-cycle PATTERN_LOAD pulse.
module dutypattern_loader
  import dutypattern_pkg::*;
#(
  parameter int                   PATTERN_W       = PATTERN_W_DEF,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(DEFAULT_PATTERN_DEF)
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_N,
  dutypattern_loader_if.master     fifo,
  output logic [PATTERN_W-1:0]     PATTERN_OUT,
  output logic                     PATTERN_LOAD,
  output logic                     BUSY,
  output logic [FRAME_COUNT_W-1:0] FRAME_COUNT,
  output logic                     UNDERFLOW,
  output state_t                   STATE_DBG
);

  localparam int CNT_W = $clog2(PATTERN_W + 1);

  state_t                   state_q;
  logic                     rd_en_q;
  logic                     cap_en_q;
  logic [CNT_W-1:0]         iss_cnt_q;
  logic [PATTERN_W-1:0]     pattern_q;
  logic                     load_q;
  logic                     busy_q;
  logic [FRAME_COUNT_W-1:0] count_q;
  logic                     underflow_q;

  logic                     underflow_now;
  logic                     deser_clear;
  logic [PATTERN_W-1:0]     deser_word;
  logic                     deser_last;

  // A read strobe met by an empty FIFO aborts the frame at this edge.
  assign underflow_now = (state_q == READ) && rd_en_q && fifo.FIFO_EMPTY;
  // Shifter only accumulates while reading; anything else wipes it.
  assign deser_clear   = (state_q != READ) || underflow_now;

  dutypattern_deser #(
    .PATTERN_W (PATTERN_W)
  ) u_deser (
    .clk_i    (CLK_IN),
    .rst_ni   (RESET_N),
    .clear_i  (deser_clear),
    .cap_en_i (cap_en_q),
    .din_i    (fifo.FIFO_DOUT),
    .word_o   (deser_word),
    .last_o   (deser_last)
  );

  // Loader FSM with all outputs registered; BUSY is decoded from the next state.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      cap_en_q    <= 1'b0;
      iss_cnt_q   <= '0;
      pattern_q   <= DEFAULT_PATTERN;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      load_q   <= 1'b0;
      cap_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo.FIFO_PROG_FULL) begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            iss_cnt_q <= CNT_W'(1);
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          if (underflow_now) begin
            underflow_q <= 1'b1;
            rd_en_q     <= 1'b0;
            iss_cnt_q   <= '0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else begin
            // Bit sampled at this edge is valid next cycle, so capture then.
            cap_en_q <= rd_en_q;
            if (rd_en_q) begin
              if (iss_cnt_q == CNT_W'(PATTERN_W)) begin
                rd_en_q <= 1'b0;
              end else begin
                iss_cnt_q <= iss_cnt_q + CNT_W'(1);
              end
            end
            if (deser_last) begin
              state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          pattern_q <= deser_word;
          load_q    <= 1'b1;
          count_q   <= count_q + FRAME_COUNT_W'(1);
          iss_cnt_q <= '0;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.FIFO_RD_EN = rd_en_q;
  assign PATTERN_OUT     = pattern_q;
  assign PATTERN_LOAD    = load_q;
  assign BUSY            = busy_q;
  assign FRAME_COUNT     = count_q;
  assign UNDERFLOW       = underflow_q;
  assign STATE_DBG       = state_q;

endmodule

// File: tb/tb_dutypattern_loader.sv
// Directed bench for the duty-pattern loader with a bit-serial FIFO model.
module tb_dutypattern_loader;
  import dutypattern_pkg::*;

  localparam logic [31:0] DEF_PAT = 32'h0000FFFF;

  logic        CLK_IN  = 1'b0;
  logic        RESET_N = 1'b1;
  logic [31:0] PATTERN_OUT;
  logic        PATTERN_LOAD;
  logic        BUSY;
  logic [7:0]  FRAME_COUNT;
  logic        UNDERFLOW;
  state_t      STATE_DBG;

  dutypattern_loader_if fifo_bus();

  dutypattern_loader dut (
    .CLK_IN       (CLK_IN),
    .RESET_N      (RESET_N),
    .fifo         (fifo_bus.master),
    .PATTERN_OUT  (PATTERN_OUT),
    .PATTERN_LOAD (PATTERN_LOAD),
    .BUSY         (BUSY),
    .FRAME_COUNT  (FRAME_COUNT),
    .UNDERFLOW    (UNDERFLOW),
    .STATE_DBG    (STATE_DBG)
  );

  // Clock / reset block
  always #5 CLK_IN = ~CLK_IN;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pattern = DEF_PAT;
  logic [7:0]  exp_frames  = 8'd0;

  // FIFO model: pops at edges that sample RD_EN high and not empty; the
  // popped bit and the new empty flag appear at the following negedge.
  bit   fifo_q[$];
  bit   rd_seen;
  logic force_empty = 1'b0;

  always @(posedge CLK_IN) rd_seen = fifo_bus.FIFO_RD_EN && !fifo_bus.FIFO_EMPTY;

  always @(negedge CLK_IN) begin
    if (rd_seen && fifo_q.size() > 0) fifo_bus.FIFO_DOUT = fifo_q.pop_front();
    fifo_bus.FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) fifo_q.push_back(w[i]);
  endtask

  function automatic logic [31:0] wrap_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, b ^ 8'h5A, ~b, 8'hC3};
  endfunction

  task automatic test_reset();
    int loads = 0;
    int rd_hi = 0;
    int busy_hi = 0;
    fifo_bus.FIFO_PROG_FULL = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (PATTERN_OUT !== DEF_PAT) begin failures++; $display("FAIL reset_pattern got=%h exp=%h", PATTERN_OUT, DEF_PAT); end
    checks++; if (fifo_bus.FIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_bus.FIFO_RD_EN); end
    repeat (3) tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (PATTERN_LOAD) loads++;
      if (fifo_bus.FIFO_RD_EN) rd_hi++;
      if (BUSY) busy_hi++;
    end
    checks++; if (loads !== 0) begin failures++; $display("FAIL reset_no_load got=%0d exp=0", loads); end
    checks++; if (rd_hi !== 0) begin failures++; $display("FAIL reset_no_read got=%0d exp=0", rd_hi); end
    checks++; if (busy_hi !== 0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy_hi); end
    checks++; if (PATTERN_OUT !== DEF_PAT) begin failures++; $display("FAIL reset_pattern_idle got=%h exp=%h", PATTERN_OUT, DEF_PAT); end
    checks++; if (FRAME_COUNT !== 8'd0) begin failures++; $display("FAIL reset_frames got=%0d exp=0", FRAME_COUNT); end
    checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", UNDERFLOW); end
    checks++; if (STATE_DBG !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", STATE_DBG, IDLE); end
  endtask

  task automatic test_single_frame();
    int rd_cycles = 0;
    int loads = 0;
    int load_edge = -1;
    push_word(32'hA5C3_0F01);
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (e == 0) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (fifo_bus.FIFO_RD_EN) rd_cycles++;
      if (PATTERN_LOAD) begin loads++; load_edge = e; end
      if (e == 5) begin
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", BUSY); end
      end
      if (e == 33) begin
        checks++; if (PATTERN_OUT !== exp_pattern) begin failures++; $display("FAIL single_no_partial got=%h exp=%h", PATTERN_OUT, exp_pattern); end
        checks++; if (STATE_DBG !== COMMIT) begin failures++; $display("FAIL single_commit_state got=%0d exp=%0d", STATE_DBG, COMMIT); end
      end
    end
    exp_pattern = 32'hA5C3_0F01;
    exp_frames  = exp_frames + 8'd1;
    checks++; if (rd_cycles !== 32) begin failures++; $display("FAIL single_rd_cycles got=%0d exp=32", rd_cycles); end
    checks++; if (loads !== 1) begin failures++; $display("FAIL single_loads got=%0d exp=1", loads); end
    checks++; if (load_edge !== 34) begin failures++; $display("FAIL single_load_edge got=%0d exp=34", load_edge); end
    checks++; if (PATTERN_OUT !== exp_pattern) begin failures++; $display("FAIL single_pattern got=%h exp=%h", PATTERN_OUT, exp_pattern); end
    checks++; if (FRAME_COUNT !== exp_frames) begin failures++; $display("FAIL single_frames got=%0d exp=%0d", FRAME_COUNT, exp_frames); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int          edges [3];
    int          loads = 0;
    words[0] = 32'h1357_9BDF;
    words[1] = 32'hFFFF_0000;
    words[2] = 32'h8000_0001;
    for (int i = 0; i < 3; i++) push_word(words[i]);
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    for (int e = 0; e <= 120; e++) begin
      tick();
      if (e == 70) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (PATTERN_LOAD) begin
        if (loads < 3) begin
          edges[loads] = e;
          checks++; if (PATTERN_OUT !== words[loads]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", loads, PATTERN_OUT, words[loads]); end
        end
        loads++;
      end
    end
    exp_pattern = words[2];
    exp_frames  = exp_frames + 8'd3;
    checks++; if (loads !== 3) begin failures++; $display("FAIL b2b_loads got=%0d exp=3", loads); end
    if (loads == 3) begin
      checks++; if (edges[0] !== 34) begin failures++; $display("FAIL b2b_first_edge got=%0d exp=34", edges[0]); end
      checks++; if (edges[1] - edges[0] !== 35) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=35", edges[1] - edges[0]); end
      checks++; if (edges[2] - edges[1] !== 35) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=35", edges[2] - edges[1]); end
    end
    checks++; if (FRAME_COUNT !== exp_frames) begin failures++; $display("FAIL b2b_frames got=%0d exp=%0d", FRAME_COUNT, exp_frames); end
  endtask

  task automatic test_underflow();
    int loads = 0;
    int load_edge = -1;
    push_word(32'h1234_5678);
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    for (int e = 0; e <= 45; e++) begin
      tick();
      if (e == 0) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (e == 9) force_empty = 1'b1;
      if (e == 10) begin
        checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("FAIL uf_flag got=%b exp=1", UNDERFLOW); end
        checks++; if (fifo_bus.FIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL uf_rd_en got=%b exp=0", fifo_bus.FIFO_RD_EN); end
        checks++; if (STATE_DBG !== IDLE) begin failures++; $display("FAIL uf_state got=%0d exp=%0d", STATE_DBG, IDLE); end
        force_empty = 1'b0;
      end
      if (PATTERN_LOAD) loads++;
    end
    checks++; if (loads !== 0) begin failures++; $display("FAIL uf_no_load got=%0d exp=0", loads); end
    checks++; if (PATTERN_OUT !== exp_pattern) begin failures++; $display("FAIL uf_pattern_kept got=%h exp=%h", PATTERN_OUT, exp_pattern); end
    checks++; if (FRAME_COUNT !== exp_frames) begin failures++; $display("FAIL uf_frames got=%0d exp=%0d", FRAME_COUNT, exp_frames); end
    fifo_q.delete();
    push_word(32'h0F0F_7E81);
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    loads = 0;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (e == 0) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (PATTERN_LOAD) begin loads++; load_edge = e; end
    end
    exp_pattern = 32'h0F0F_7E81;
    exp_frames  = exp_frames + 8'd1;
    checks++; if (load_edge !== 34 || loads !== 1) begin failures++; $display("FAIL uf_recover_load got=%0d/%0d exp=34/1", load_edge, loads); end
    checks++; if (PATTERN_OUT !== exp_pattern) begin failures++; $display("FAIL uf_recover_pattern got=%h exp=%h", PATTERN_OUT, exp_pattern); end
    checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", UNDERFLOW); end
  endtask

  task automatic test_reset_mid_frame();
    int loads = 0;
    push_word(32'hDEAD_BEEF);
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 0) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (PATTERN_LOAD) loads++;
    end
    RESET_N = 1'b0;
    #1;
    checks++; if (fifo_bus.FIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", fifo_bus.FIFO_RD_EN); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", BUSY); end
    checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("FAIL mid_underflow got=%b exp=0", UNDERFLOW); end
    checks++; if (FRAME_COUNT !== 8'd0) begin failures++; $display("FAIL mid_frames got=%0d exp=0", FRAME_COUNT); end
    checks++; if (PATTERN_OUT !== DEF_PAT) begin failures++; $display("FAIL mid_pattern got=%h exp=%h", PATTERN_OUT, DEF_PAT); end
    checks++; if (STATE_DBG !== IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", STATE_DBG, IDLE); end
    repeat (2) tick();
    fifo_q.delete();
    RESET_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (PATTERN_LOAD) loads++;
    end
    exp_pattern = DEF_PAT;
    exp_frames  = 8'd0;
    checks++; if (loads !== 0) begin failures++; $display("FAIL mid_no_load got=%0d exp=0", loads); end
    checks++; if (PATTERN_OUT !== exp_pattern) begin failures++; $display("FAIL mid_pattern_after got=%h exp=%h", PATTERN_OUT, exp_pattern); end
  endtask

  task automatic test_wrap();
    int loads = 0;
    for (int k = 0; k < 256; k++) push_word(wrap_word(k));
    repeat (2) tick();
    fifo_bus.FIFO_PROG_FULL = 1'b1;
    for (int e = 0; e <= 8970; e++) begin
      tick();
      if (e == 8925) fifo_bus.FIFO_PROG_FULL = 1'b0;
      if (PATTERN_LOAD) begin
        checks++; if (PATTERN_OUT !== wrap_word(loads)) begin failures++; $display("FAIL wrap_word%0d got=%h exp=%h", loads, PATTERN_OUT, wrap_word(loads)); end
        loads++;
        if (loads == 255) begin
          checks++; if (FRAME_COUNT !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", FRAME_COUNT); end
        end
      end
    end
    checks++; if (loads !== 256) begin failures++; $display("FAIL wrap_loads got=%0d exp=256", loads); end
    checks++; if (FRAME_COUNT !== 8'd0) begin failures++; $display("FAIL wrap_frames got=%0d exp=0", FRAME_COUNT); end
    checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("FAIL wrap_underflow got=%b exp=0", UNDERFLOW); end
  endtask

  // Scenario sequence and final report
  initial begin
    fifo_bus.FIFO_PROG_FULL = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underflow();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
